// File: rtl/ser_par_lane_pkg.sv
// Shared receive-path definitions: idle/comma symbol and lane FSM encoding.
// Also imported by the striping and unstriping stages.
package ser_par_lane_pkg;

    // Comma/idle symbol used for byte alignment and as the idle filler.
    localparam logic [7:0] COM_SYMBOL = 8'hBC;

    typedef enum logic [1:0] {
        StSearch  = 2'd0,
        StLocking = 2'd1,
        StActive  = 2'd2
    } lane_state_e;

    function automatic logic is_com(input logic [7:0] word, input logic [7:0] com);
        return word == com;
    endfunction

endpackage

// File: rtl/ser_par_lane.sv
// Receive-side serial-to-parallel converter for one lane.
// Deserialises an MSB-first bit stream, hunts for COM to find byte boundaries,
// locks after AlignCount consecutive aligned COMs, then emits one byte every 8 clocks.
module ser_par_lane
    import ser_par_lane_pkg::*;
#(
    parameter logic [7:0]  ComSymbol  = ser_par_lane_pkg::COM_SYMBOL,
    parameter int unsigned AlignCount = 4  // 1..15
) (
    input  logic       clk_8f,
    input  logic       reset_L,
    input  logic       data_serial,
    output logic [7:0] data_parallel,
    output logic       valid_parallel,
    output logic       byte_strobe,
    output logic       active
);

    localparam logic [3:0] AlignCountW = 4'(AlignCount);

    lane_state_e state_q, state_d;
    logic [7:0]  shreg_q;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  com_cnt_q, com_cnt_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        upd_q, upd_d;       // byte captured this edge; strobe follows one cycle later
    logic        strobe_q;
    logic        active_q, active_d;

    logic [7:0]  word;
    logic        boundary;
    logic        word_is_com;

    // Byte completed at this edge and boundary detection.
    always_comb begin
        word        = {shreg_q[6:0], data_serial};
        boundary    = (bit_cnt_q == 3'd7);
        word_is_com = is_com(word, ComSymbol);
    end

    // Next-state logic: alignment FSM, counters and output capture.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q + 3'd1;
        com_cnt_d = com_cnt_q;
        data_d    = data_q;
        valid_d   = valid_q;
        upd_d     = 1'b0;
        active_d  = active_q;

        unique case (state_q)
            StSearch: begin
                // Any bit position may start a byte; a COM match fixes the boundary.
                if (word_is_com) begin
                    bit_cnt_d = 3'd0;
                    com_cnt_d = 4'd1;
                    if (AlignCount == 1) begin
                        state_d  = StActive;
                        active_d = 1'b1;
                    end else begin
                        state_d = StLocking;
                    end
                end
            end
            StLocking: begin
                // Only boundary-aligned words count; misaligned COMs are ignored.
                if (boundary) begin
                    if (word_is_com) begin
                        if (com_cnt_q + 4'd1 == AlignCountW) begin
                            state_d  = StActive;
                            active_d = 1'b1;
                        end else begin
                            com_cnt_d = com_cnt_q + 4'd1;
                        end
                    end else begin
                        state_d   = StSearch;
                        com_cnt_d = 4'd0;
                    end
                end
            end
            StActive: begin
                // No loss-of-lock detection: only reset leaves this state.
                if (boundary) begin
                    data_d  = word;
                    valid_d = !word_is_com;
                    upd_d   = 1'b1;
                end
            end
            default: begin
                state_d = StSearch;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk_8f or negedge reset_L) begin
        if (!reset_L) begin
            state_q   <= StSearch;
            shreg_q   <= 8'h00;
            bit_cnt_q <= 3'd0;
            com_cnt_q <= 4'd0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            upd_q     <= 1'b0;
            strobe_q  <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= word;
            bit_cnt_q <= bit_cnt_d;
            com_cnt_q <= com_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            upd_q     <= upd_d;
            strobe_q  <= upd_q;
            active_q  <= active_d;
        end
    end

    // Registered outputs.
    always_comb begin
        data_parallel  = data_q;
        valid_parallel = valid_q;
        byte_strobe    = strobe_q;
        active         = active_q;
    end

endmodule

// File: tb/tb_ser_par_lane.sv
// Self-checking bench for ser_par_lane: table-driven data vectors with a strobe-driven
// scoreboard, plus hand-written lock, broken-lock, misaligned-COM and async-reset sequences.
module tb_ser_par_lane;
    import ser_par_lane_pkg::*;

    logic       clk_8f = 1'b0;
    logic       reset_L = 1'b0;
    logic       data_serial = 1'b0;
    logic [7:0] data_parallel;
    logic       valid_parallel;
    logic       byte_strobe;
    logic       active;

    ser_par_lane dut (
        .clk_8f         (clk_8f),
        .reset_L        (reset_L),
        .data_serial    (data_serial),
        .data_parallel  (data_parallel),
        .valid_parallel (valid_parallel),
        .byte_strobe    (byte_strobe),
        .active         (active)
    );

    always #5 clk_8f = ~clk_8f;

    int total = 0;
    int bad = 0;
    int edge_cnt = 0;
    int lock_edge = -1;

    typedef struct packed {
        logic [7:0] data;
        logic       valid;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp_data;
        logic       exp_valid;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, req, edge_cnt);
        end
    endtask

    // Drive one bit at negedge, sample #1 after the posedge, check strobe and scoreboard.
    task automatic send_bit(input logic b);
        logic exp_strobe;
        exp_t e;
        @(negedge clk_8f);
        data_serial = b;
        @(posedge clk_8f);
        #1;
        edge_cnt++;
        exp_strobe = (lock_edge >= 0) && (edge_cnt > lock_edge + 1) &&
                     (((edge_cnt - lock_edge) % 8) == 1);
        chk("byte_strobe", byte_strobe, exp_strobe);
        if (byte_strobe === 1'b1) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sb_underflow: strobe seen with no expected byte (edge %0d)",
                         edge_cnt);
            end else begin
                total--;
                e = sb_q.pop_front();
                chk("sb_data", data_parallel, e.data);
                chk("sb_valid", valid_parallel, e.valid);
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        data_serial = 1'b0;
        repeat (2) @(posedge clk_8f);
        #2;
        reset_L = 1'b1;
        edge_cnt = 0;
        lock_edge = -1;
        sb_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        logic [7:0] b;
        vecs[0] = '{8'hA5, 8'hA5, 1'b1};
        vecs[1] = '{8'h3C, 8'h3C, 1'b1};
        vecs[2] = '{8'hBC, 8'hBC, 1'b0};
        vecs[3] = '{8'hFF, 8'hFF, 1'b1};
        vecs[4] = '{8'h00, 8'h00, 1'b1};

        // Reset state
        do_reset();
        chk("rst_data", data_parallel, 8'h00);
        chk("rst_valid", valid_parallel, 1'b0);
        chk("rst_strobe", byte_strobe, 1'b0);
        chk("rst_active", active, 1'b0);
        chk("rst_state", dut.state_q, StSearch);

        // Lock: 3 random bits then 4 COMs; active rises exactly at edge 35
        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
        for (int k = 0; k < 3; k++) begin
            send_byte(8'hBC);
            chk("lock_pre_active", active, 1'b0);
        end
        b = 8'hBC;
        for (int i = 7; i >= 1; i--) send_bit(b[i]);
        chk("lock_edge34_active", active, 1'b0);
        send_bit(b[0]);
        chk("lock_edge35_active", active, 1'b1);
        chk("lock_valid", valid_parallel, 1'b0);
        chk("lock_data", data_parallel, 8'h00);
        lock_edge = edge_cnt;

        // Data and idle after lock, table driven
        for (int v = 0; v < 5; v++) begin
            sb_q.push_back({vecs[v].din, vecs[v].din != COM_SYMBOL});
            send_byte(vecs[v].din);
            chk("vec_data", data_parallel, vecs[v].exp_data);
            chk("vec_valid", valid_parallel, vecs[v].exp_valid);
            chk("vec_active", active, 1'b1);
        end
        send_bit(1'b0);
        chk("sb_drained", sb_q.size(), 0);

        // Async reset between edges while active and data toggling
        #1 data_serial = 1'b1;
        #1 data_serial = 1'b0;
        reset_L = 1'b0;
        #1;
        chk("arst_data", data_parallel, 8'h00);
        chk("arst_valid", valid_parallel, 1'b0);
        chk("arst_strobe", byte_strobe, 1'b0);
        chk("arst_active", active, 1'b0);
        do_reset();
        for (int k = 0; k < 4; k++) begin
            send_byte(8'hBC);
            chk("relock_active", active, k == 3);
        end

        // Broken lock: BC BC 00 then 4 x BC
        do_reset();
        send_byte(8'hBC);
        chk("brk_state_lock", dut.state_q, StLocking);
        send_byte(8'hBC);
        send_byte(8'h00);
        chk("brk_state_search", dut.state_q, StSearch);
        for (int k = 0; k < 3; k++) begin
            send_byte(8'hBC);
            chk("brk_pre_active", active, 1'b0);
        end
        b = 8'hBC;
        for (int i = 7; i >= 1; i--) send_bit(b[i]);
        chk("brk_edge55_active", active, 1'b0);
        send_bit(b[0]);
        chk("brk_edge56_active", active, 1'b1);
        chk("brk_state_active", dut.state_q, StActive);

        // Misaligned COM: 0B C0 00 contains BC ending at edge 12
        do_reset();
        send_byte(8'h0B);
        b = 8'hC0;
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i]);
            if (edge_cnt == 11) chk("mis_e11_state", dut.state_q, StSearch);
            if (edge_cnt == 12) chk("mis_e12_state", dut.state_q, StLocking);
        end
        b = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i]);
            if (edge_cnt == 19) chk("mis_e19_state", dut.state_q, StLocking);
            if (edge_cnt == 20) chk("mis_e20_state", dut.state_q, StSearch);
        end
        chk("mis_active", active, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
